// File: rtl/regfile_wb_sched_if.sv
// Bundle of decode, write-back and long-unit signals around the register file write scheduler.
// The slave side is the scheduler; the master side drives decode, the pipeline and the long unit.
interface regfile_wb_sched_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
);
    logic              id_re1;
    logic [ADDR_W-1:0] id_raddr1;
    logic              id_re2;
    logic [ADDR_W-1:0] id_raddr2;
    logic              id_we;
    logic              id_issue_long;
    logic [ADDR_W-1:0] id_waddr;
    logic              stall_req;

    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;

    logic              lu_valid;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_wdata;
    logic              lu_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [REG_NUM-1:0] pending;
    logic               sb_err;

    modport master (
        output id_re1, id_raddr1, id_re2, id_raddr2, id_we, id_issue_long, id_waddr,
        output pipe_we, pipe_waddr, pipe_wdata,
        output lu_valid, lu_waddr, lu_wdata,
        input  stall_req, lu_ready, rf_we, rf_waddr, rf_wdata, pending, sb_err
    );

    modport slave (
        input  id_re1, id_raddr1, id_re2, id_raddr2, id_we, id_issue_long, id_waddr,
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  lu_valid, lu_waddr, lu_wdata,
        output stall_req, lu_ready, rf_we, rf_waddr, rf_wdata, pending, sb_err
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the 2R/1W register file: arbitrates pipeline vs long-unit writes,
// tracks outstanding long-op destinations and raises decode stalls on hazards or starvation.
module regfile_wb_sched #(
    parameter int DATA_W          = 32,
    parameter int REG_NUM         = 32,
    parameter int ADDR_W          = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_sched_if.slave    bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TMR_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STARVE_LIMIT);

    logic [REG_NUM-1:0] pending_q;
    logic [CNT_W-1:0]   count_q;
    logic [TMR_W-1:0]   starve_tmr_q;
    logic               sb_err_q;

    logic               grant;
    logic               raw1;
    logic               raw2;
    logic               waw;
    logic               cap_full;
    logic               starved;
    logic               stall;
    logic               set_en;
    logic               clr_hit;
    logic               err_evt;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;
    logic [REG_NUM-1:0] pending_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic [TMR_W-1:0]   starve_tmr_nxt;

    // Pipeline write-back always owns the port; the long unit only gets idle slots.
    assign grant = ~rst & ~bus.pipe_we & bus.lu_valid;

    assign bus.rf_we    = ~rst & (bus.pipe_we | bus.lu_valid);
    assign bus.rf_waddr = bus.pipe_we ? bus.pipe_waddr : bus.lu_waddr;
    assign bus.rf_wdata = bus.pipe_we ? bus.pipe_wdata : bus.lu_wdata;
    assign bus.lu_ready = grant;

    // A read of a register being written by the long unit this cycle is served by the rf bypass.
    assign raw1 = bus.id_re1 & (bus.id_raddr1 != '0) & pending_q[bus.id_raddr1]
                & ~(grant & (bus.lu_waddr == bus.id_raddr1));
    assign raw2 = bus.id_re2 & (bus.id_raddr2 != '0) & pending_q[bus.id_raddr2]
                & ~(grant & (bus.lu_waddr == bus.id_raddr2));
    assign waw      = (bus.id_we | bus.id_issue_long) & (bus.id_waddr != '0) & pending_q[bus.id_waddr];
    assign cap_full = bus.id_issue_long & (count_q == CNT_MAX);
    assign starved  = (starve_tmr_q == '0);

    assign stall         = ~rst & (raw1 | raw2 | waw | cap_full | starved);
    assign bus.stall_req = stall;

    assign set_en  = bus.id_issue_long & ~stall & (bus.id_waddr != '0);
    assign clr_hit = grant & pending_q[bus.lu_waddr];
    assign err_evt = (grant & ~pending_q[bus.lu_waddr] & (bus.lu_waddr != '0))
                   | (bus.pipe_we & pending_q[bus.pipe_waddr]);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) begin
            set_vec = REG_NUM'(1) << bus.id_waddr;
        end
        if (grant) begin
            clr_vec = REG_NUM'(1) << bus.lu_waddr;
        end
        pending_nxt    = (pending_q & ~clr_vec) | set_vec;
        pending_nxt[0] = 1'b0;
    end

    // Only a clear that actually retires a tracked op frees a slot, so a stray grant cannot underflow.
    always_comb begin
        count_nxt = count_q;
        case ({set_en, clr_hit})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    // Down-counts the cycles a valid long result has been refused; terminal count forces a stall.
    always_comb begin
        starve_tmr_nxt = TMR_LOAD;
        if (bus.lu_valid & ~grant) begin
            starve_tmr_nxt = (starve_tmr_q == '0) ? '0 : starve_tmr_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            count_q      <= '0;
            starve_tmr_q <= TMR_LOAD;
            sb_err_q     <= 1'b0;
        end else begin
            pending_q    <= pending_nxt;
            count_q      <= count_nxt;
            starve_tmr_q <= starve_tmr_nxt;
            sb_err_q     <= sb_err_q | err_evt;
        end
    end

    assign bus.pending = pending_q;
    assign bus.sb_err  = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: expected register-file writes are queued as stimulus
// is driven and compared when the write port fires; stall and scoreboard state are checked inline.
module tb_regfile_wb_sched;
    localparam int DATA_W  = 32;
    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) bus ();

    regfile_wb_sched #(
        .DATA_W(DATA_W), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W),
        .MAX_OUTSTANDING(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic idle();
        bus.id_re1 = 0; bus.id_raddr1 = '0; bus.id_re2 = 0; bus.id_raddr2 = '0;
        bus.id_we = 0; bus.id_issue_long = 0; bus.id_waddr = '0;
        bus.pipe_we = 0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
        bus.lu_valid = 0; bus.lu_waddr = '0; bus.lu_wdata = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.a = ADDR_W'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Write-port monitor: every rf write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rf_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rf_write unexpected: got addr %0d data %h, expected no write",
                             bus.rf_waddr, bus.rf_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.rf_waddr !== mon_e.a || bus.rf_wdata !== mon_e.d) begin
                        errors++;
                        $display("FAIL rf_write: got addr %0d data %h, expected addr %0d data %h",
                                 bus.rf_waddr, bus.rf_wdata, mon_e.a, mon_e.d);
                    end
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL rf_write missing: got rf_we %b, expected write of %0d entries",
                         bus.rf_we, exp_q.size());
                exp_q.delete();
            end
        end
    end

    task automatic test_reset();
        rst = 1;
        idle();
        bus.pipe_we = 1; bus.pipe_waddr = 5'd3; bus.pipe_wdata = 32'h1111_1111;
        bus.lu_valid = 1; bus.lu_waddr = 5'd4; bus.id_re1 = 1; bus.id_raddr1 = 5'd4;
        cyc();
        cyc();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got %b exp 0", bus.lu_ready); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall_req); end
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", bus.pending); end
        checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %b exp 0", bus.sb_err); end
        idle();
        rst = 0;
        cyc();
    endtask

    task automatic test_raw();
        bus.id_issue_long = 1; bus.id_waddr = 5'd5;
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got %b exp 0", bus.stall_req); end
        cyc();
        idle();
        checks++; if (bus.pending !== 32'h0000_0020) begin errors++; $display("FAIL raw_pending got %h exp 00000020", bus.pending); end
        bus.id_re1 = 1; bus.id_raddr1 = 5'd5;
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL raw_op1_stall got %b exp 1", bus.stall_req); end
        cyc();
        bus.id_re1 = 0; bus.id_re2 = 1; bus.id_raddr2 = 5'd5;
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL raw_op2_stall got %b exp 1", bus.stall_req); end
        bus.id_raddr2 = 5'd6;
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL raw_other_reg_stall got %b exp 0", bus.stall_req); end
        cyc();
        idle();
    endtask

    task automatic test_bypass();
        bus.id_re1 = 1; bus.id_raddr1 = 5'd5;
        bus.lu_valid = 1; bus.lu_waddr = 5'd5; bus.lu_wdata = 32'hDEAD_BEEF;
        push_wr(5, 32'hDEAD_BEEF);
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL bypass_lu_ready got %b exp 1", bus.lu_ready); end
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL bypass_rf got we %b addr %0d exp we 1 addr 5", bus.rf_we, bus.rf_waddr); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL bypass_stall got %b exp 0", bus.stall_req); end
        cyc();
        idle();
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL bypass_pending_clear got %h exp 0", bus.pending); end
    endtask

    task automatic test_starve();
        logic exp_st;
        logic [DATA_W-1:0] d;
        bus.id_issue_long = 1; bus.id_waddr = 5'd9;
        cyc();
        idle();
        bus.lu_valid = 1; bus.lu_waddr = 5'd9; bus.lu_wdata = 32'h1234_5678;
        for (int i = 0; i < 9; i++) begin
            d = $urandom;
            bus.pipe_we = 1; bus.pipe_waddr = ADDR_W'(10 + i); bus.pipe_wdata = d;
            push_wr(10 + i, d);
            exp_st = (i >= 8);
            #1;
            checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL starve_lu_ready cycle %0d got %b exp 0", i, bus.lu_ready); end
            checks++; if (bus.stall_req !== exp_st) begin errors++; $display("FAIL starve_stall cycle %0d got %b exp %b", i, bus.stall_req, exp_st); end
            cyc();
        end
        bus.pipe_we = 0;
        push_wr(9, 32'h1234_5678);
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL starve_grant got %b exp 1", bus.lu_ready); end
        cyc();
        idle();
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_release got %b exp 0", bus.stall_req); end
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL starve_pending got %h exp 0", bus.pending); end
    endtask

    task automatic test_zero_reg();
        for (int i = 0; i < 5; i++) begin
            bus.id_issue_long = 1; bus.id_waddr = 5'd0;
            #1;
            checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL r0_issue_stall %0d got %b exp 0", i, bus.stall_req); end
            cyc();
        end
        idle();
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL r0_pending got %h exp 0", bus.pending); end
    endtask

    task automatic test_capacity();
        int drain [4] = '{1, 3, 4, 6};
        logic [DATA_W-1:0] d;
        for (int a = 1; a <= 4; a++) begin
            bus.id_issue_long = 1; bus.id_waddr = ADDR_W'(a);
            #1;
            checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL cap_fill r%0d got %b exp 0", a, bus.stall_req); end
            cyc();
        end
        bus.id_issue_long = 1; bus.id_waddr = 5'd6;
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL cap_full_stall got %b exp 1", bus.stall_req); end
        cyc();
        bus.lu_valid = 1; bus.lu_waddr = 5'd2; bus.lu_wdata = 32'hCAFE_0002;
        push_wr(2, 32'hCAFE_0002);
        #1;
        checks++; if (bus.lu_ready !== 1'b1 || bus.stall_req !== 1'b1) begin errors++; $display("FAIL cap_grant_cycle got ready %b stall %b exp 1 1", bus.lu_ready, bus.stall_req); end
        cyc();
        bus.lu_valid = 0;
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL cap_accept got %b exp 0", bus.stall_req); end
        cyc();
        idle();
        checks++; if (bus.pending !== 32'h0000_005A) begin errors++; $display("FAIL cap_pending got %h exp 0000005a", bus.pending); end
        bus.id_issue_long = 1; bus.id_waddr = 5'd7;
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL cap_count4 got %b exp 1", bus.stall_req); end
        idle();
        bus.id_we = 1; bus.id_waddr = 5'd3;
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", bus.stall_req); end
        bus.id_waddr = 5'd5;
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL waw_free_reg got %b exp 0", bus.stall_req); end
        cyc();
        idle();
        foreach (drain[k]) begin
            d = $urandom;
            bus.lu_valid = 1; bus.lu_waddr = ADDR_W'(drain[k]); bus.lu_wdata = d;
            push_wr(drain[k], d);
            cyc();
        end
        idle();
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL cap_drain got %h exp 0", bus.pending); end
    endtask

    task automatic test_sb_err();
        checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL err_clean got %b exp 0", bus.sb_err); end
        bus.lu_valid = 1; bus.lu_waddr = 5'd7; bus.lu_wdata = 32'h0BAD_0007;
        push_wr(7, 32'h0BAD_0007);
        #1;
        checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL err_grant got %b exp 1", bus.lu_ready); end
        cyc();
        idle();
        checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", bus.sb_err); end
        cyc(); cyc(); cyc();
        checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.sb_err); end
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL err_pending got %h exp 0", bus.pending); end
    endtask

    task automatic test_reset_mid();
        for (int a = 1; a <= 3; a++) begin
            bus.id_issue_long = 1; bus.id_waddr = ADDR_W'(a);
            cyc();
        end
        idle();
        checks++; if (bus.pending !== 32'h0000_000E) begin errors++; $display("FAIL mid_pending got %h exp 0000000e", bus.pending); end
        rst = 1;
        bus.pipe_we = 1; bus.pipe_waddr = 5'd8; bus.pipe_wdata = 32'h5555_AAAA;
        bus.lu_valid = 1; bus.lu_waddr = 5'd1;
        bus.id_re1 = 1; bus.id_raddr1 = 5'd1;
        #1;
        checks++; if (bus.rf_we !== 1'b0 || bus.lu_ready !== 1'b0 || bus.stall_req !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs got we %b ready %b stall %b exp 0 0 0", bus.rf_we, bus.lu_ready, bus.stall_req); end
        cyc();
        checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL mid_rst_pending got %h exp 0", bus.pending); end
        checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL mid_rst_sb_err got %b exp 0", bus.sb_err); end
        rst = 0;
        idle();
        bus.id_re1 = 1; bus.id_raddr1 = 5'd1;
        bus.id_issue_long = 1; bus.id_waddr = 5'd1;
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL mid_post_rst_stall got %b exp 0", bus.stall_req); end
        cyc();
        idle();
        bus.lu_valid = 1; bus.lu_waddr = 5'd1; bus.lu_wdata = 32'h0000_0042;
        push_wr(1, 32'h0000_0042);
        cyc();
        idle();
        checks++; if (bus.pending !== 32'h0 || bus.sb_err !== 1'b0) begin errors++; $display("FAIL mid_final got pending %h err %b exp 0 0", bus.pending, bus.sb_err); end
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_bypass();
        test_starve();
        test_zero_reg();
        test_capacity();
        test_sb_err();
        test_reset_mid();
        cyc();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d outstanding writes exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
